// File: rtl/udm_uart_tx.sv
// UDM link UART transmitter: FIFO-buffered bytes serialised 8N1/8N2 at a runtime bit period.
// Define UDM_UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1/8E2).
module udm_uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic [31:0]   div_i,
  input  logic          tx_req_i,
  input  logic [7:0]    tx_data_i,
  output logic          tx_ack_o,
  output logic          tx_o,
  output logic          busy_o,
  output logic [LW-1:0] level_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UDM_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          tx_q, tx_d;
  logic [31:0]   timer_q, timer_d, period_q, period_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
`ifdef UDM_UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic        push, pop, bit_end, start_frame;
  logic [31:0] div_clamp;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign tx_ack_o  = (count_q != LW'(FIFO_DEPTH));
  assign push      = tx_req_i && tx_ack_o;
  assign bit_end   = (timer_q == '0);
  assign div_clamp = (div_i < 32'd2) ? 32'd2 : div_i;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    timer_d     = timer_q;
    period_d    = period_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    start_frame = 1'b0;
    pop         = 1'b0;
`ifdef UDM_UART_TX_PARITY_EN
    par_d       = par_q;
`endif
    if (state_q != S_IDLE && !bit_end) timer_d = timer_q - 32'd1;

    case (state_q)
      S_IDLE: start_frame = (count_q != '0);
      S_START: if (bit_end) begin
        state_d   = S_DATA;
        tx_d      = shift_q[0];
        timer_d   = period_q - 32'd1;
        bit_cnt_d = '0;
      end
      S_DATA: if (bit_end) begin
        timer_d = period_q - 32'd1;
        if (bit_cnt_q == 3'd7) begin
`ifdef UDM_UART_TX_PARITY_EN
          state_d = S_PARITY;
          tx_d    = par_q;
`else
          state_d   = S_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = {1'b0, shift_q[7:1]};
          tx_d      = shift_q[1];
        end
      end
`ifdef UDM_UART_TX_PARITY_EN
      S_PARITY: if (bit_end) begin
        state_d   = S_STOP;
        tx_d      = 1'b1;
        timer_d   = period_q - 32'd1;
        bit_cnt_d = '0;
      end
`endif
      S_STOP: if (bit_end) begin
        if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
          // Chain straight into the next start bit when more data is queued.
          if (count_q != '0) begin
            start_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          timer_d   = period_q - 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (start_frame) begin
      pop      = 1'b1;
      state_d  = S_START;
      tx_d     = 1'b0;
      shift_d  = mem_q[rd_ptr_q];
      period_d = div_clamp;
      timer_d  = div_clamp - 32'd1;
`ifdef UDM_UART_TX_PARITY_EN
      par_d    = ^mem_q[rd_ptr_q];
`endif
    end
  end

  assign wr_ptr_d = wr_ptr_q + AW'(push);
  assign rd_ptr_d = rd_ptr_q + AW'(pop);
  assign count_d  = count_q + LW'(push) - LW'(pop);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      timer_q   <= '0;
      period_q  <= 32'd2;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UDM_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      tx_q      <= tx_d;
      timer_q   <= timer_d;
      period_q  <= period_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UDM_UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign tx_o    = tx_q;
  assign busy_o  = (state_q != S_IDLE) || (count_q != '0);
  assign level_o = count_q;

endmodule

// File: tb/tb_udm_uart_tx.sv
// Directed bench for udm_uart_tx: scoreboard of expected bytes/periods checked by a line receiver.
module tb_udm_uart_tx;
  localparam int LW = 3;
`ifdef UDM_UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB = 10 + PB;

  typedef struct {
    logic [7:0] dat;
    int         per;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          arst_n_i;
  logic [31:0]   div_i;
  logic          tx_req_i;
  logic [7:0]    tx_data_i;
  logic          tx_ack_o;
  logic          tx_o;
  logic          busy_o;
  logic [LW-1:0] level_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  bit   rx_en;
  bit   rx_busy;
  int   rx_cnt, rx_per, t0, t1;
  logic [7:0] rx_dat, rx_byte;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  udm_uart_tx #(.FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .div_i(div_i),
    .tx_req_i(tx_req_i), .tx_data_i(tx_data_i), .tx_ack_o(tx_ack_o),
    .tx_o(tx_o), .busy_o(busy_o), .level_o(level_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for bit slot k of a frame carrying d.
  function automatic logic fbit(input int k, input logic [7:0] d);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (PB == 1 && k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] d, input int per, input bit track);
    tx_req_i  = 1'b1;
    tx_data_i = d;
    for (int i = 0; i < 1000 && tx_ack_o !== 1'b1; i++) @(negedge clk_i);
    check("push_ack", tx_ack_o, 1);
    if (track) sb.push_back('{dat: d, per: per});
    @(negedge clk_i);
  endtask

  task automatic wait_idle(input string tag, output int t_end);
    for (int i = 0; i < 4000 && busy_o !== 1'b0; i++) @(negedge clk_i);
    check(tag, busy_o, 0);
    t_end = cyc;
  endtask

  initial begin
    rx_en     = 1'b0;
    rx_busy   = 1'b0;
    arst_n_i  = 1'b0;
    tx_req_i  = 1'b0;
    tx_data_i = 8'h00;
    div_i     = 32'd4;

    fork
      forever begin
        @(negedge clk_i);
        if (!rx_en) begin
          rx_busy = 1'b0;
        end else if (rx_busy) begin
          rx_cnt++;
          if (rx_cnt % rx_per == rx_per / 2) begin
            if (rx_cnt / rx_per >= 1 && rx_cnt / rx_per <= 8) rx_byte[rx_cnt / rx_per - 1] = tx_o;
            else check("rx_framing_bit", tx_o, fbit(rx_cnt / rx_per, rx_dat));
            if (rx_cnt / rx_per == NB - 1) begin
              check("rx_byte", rx_byte, rx_dat);
              rx_busy = 1'b0;
            end
          end
        end else if (tx_o === 1'b0) begin
          check("rx_expected_frame", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            exp_t e;
            e       = sb.pop_front();
            rx_dat  = e.dat;
            rx_per  = e.per;
            rx_byte = 8'h00;
            rx_cnt  = 0;
            rx_busy = 1'b1;
          end
        end
      end
    join_none

    // Reset and idle behaviour.
    @(negedge clk_i);
    check("in_reset", {tx_o, busy_o, level_o}, {1'b1, 1'b0, 3'd0});
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    rx_en    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      check("idle_state", {tx_o, busy_o, tx_ack_o, level_o}, {1'b1, 1'b0, 1'b1, 3'd0});
    end

    // Single byte with cycle-exact frame shape.
    div_i = 32'd4;
    push_byte(8'h55, 4, 1'b1);
    tx_req_i = 1'b0;
    check("pre_start_tx", {tx_o, level_o}, {1'b1, 3'd1});
    @(negedge clk_i);
    for (int i = 0; i < NB * 4; i++) begin
      check("single_frame_bit", tx_o, fbit(i / 4, 8'h55));
      @(negedge clk_i);
    end
    check("single_post_busy", {busy_o, tx_o}, {1'b0, 1'b1});

    // Back-to-back frames, no gap between stop and next start.
    div_i = 32'd8;
    repeat (3) @(negedge clk_i);
    t0 = cyc;
    check("b2b_ack0", tx_ack_o, 1); push_byte(8'hA5, 8, 1'b1);
    check("b2b_ack1", tx_ack_o, 1); push_byte(8'h3C, 8, 1'b1);
    check("b2b_ack2", tx_ack_o, 1); push_byte(8'hFF, 8, 1'b1);
    check("b2b_ack3", tx_ack_o, 1); push_byte(8'h00, 8, 1'b1);
    tx_req_i = 1'b0;
    wait_idle("b2b_idle", t1);
    check("b2b_duration", t1 - t0, 2 + 4 * NB * 8);

    // Full FIFO backpressure.
    div_i = 32'd16;
    repeat (3) @(negedge clk_i);
    push_byte(8'h11, 16, 1'b1);
    push_byte(8'h22, 16, 1'b1);
    push_byte(8'h33, 16, 1'b1);
    push_byte(8'h44, 16, 1'b1);
    push_byte(8'h55, 16, 1'b1);
    check("full_ack_level", {tx_ack_o, level_o}, {1'b0, 3'd4});
    push_byte(8'h66, 16, 1'b1);
    tx_req_i = 1'b0;
    check("refill_level", level_o, 4);
    wait_idle("full_idle", t1);

    // Divider clamp to 2 cycles per bit.
    div_i = 32'd0;
    repeat (3) @(negedge clk_i);
    t0 = cyc;
    push_byte(8'h5A, 2, 1'b1);
    tx_req_i = 1'b0;
    wait_idle("clamp0_idle", t1);
    check("clamp0_duration", t1 - t0, 2 + NB * 2);
    div_i = 32'd1;
    t0 = cyc;
    push_byte(8'hC3, 2, 1'b1);
    tx_req_i = 1'b0;
    wait_idle("clamp1_idle", t1);
    check("clamp1_duration", t1 - t0, 2 + NB * 2);

    // Divider change mid-frame takes effect on the next frame only.
    div_i = 32'd8;
    repeat (3) @(negedge clk_i);
    t0 = cyc;
    push_byte(8'h33, 8, 1'b1);
    push_byte(8'hCC, 16, 1'b1);
    tx_req_i = 1'b0;
    repeat (20) @(negedge clk_i);
    div_i = 32'd16;
    wait_idle("divchg_idle", t1);
    check("divchg_duration", t1 - t0, 2 + NB * 8 + NB * 16);

`ifdef UDM_UART_TX_PARITY_EN
    div_i = 32'd4;
    push_byte(8'h07, 4, 1'b1);
    push_byte(8'h03, 4, 1'b1);
    tx_req_i = 1'b0;
    wait_idle("parity_idle", t1);
`endif

    // Asynchronous reset in the middle of a frame with bytes queued.
    check("sb_drained", sb.size(), 0);
    rx_en = 1'b0;
    div_i = 32'd8;
    repeat (3) @(negedge clk_i);
    push_byte(8'h81, 8, 1'b0);
    push_byte(8'h18, 8, 1'b0);
    push_byte(8'h24, 8, 1'b0);
    tx_req_i = 1'b0;
    repeat (18) @(negedge clk_i);
    check("pre_reset_tx_level", {tx_o, level_o}, {1'b0, 3'd2});
    #2 arst_n_i = 1'b0;
    #1 check("async_reset", {tx_o, busy_o, level_o}, {1'b1, 1'b0, 3'd0});
    repeat (3) @(negedge clk_i);
    arst_n_i = 1'b1;
    rx_en    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      check("post_reset_quiet", {tx_o, busy_o, level_o}, {1'b1, 1'b0, 3'd0});
    end

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
